// File: rtl/sar_code_accum.sv
// rtl/sar_code_accum.sv - SAR conversion capture, complement check, averaging and result FIFO
//
// Purpose:
//   Captures one SAR switch-control word per comparator window (at the falling
//   edge of comp_en), rejects words whose d/db pairs are not complementary,
//   averages 2^AVG_LOG2 valid codes and queues each mean in a small FIFO that
//   a downstream reader drains with out_valid/out_ready.
//
// Ports:
//   clk         system clock (shared with the comp_en/sample source)
//   rst_n       asynchronous active-low reset
//   comp_en     comparator-phase enable; its 1->0 transition marks end of conversion
//   sample      sampling phase; only used to flag overlap with comp_en
//   d_code      {d1..d6}, d1 is the MSB
//   d_code_b    {d1b..d6b}, expected bitwise complement of d_code
//   clr         synchronous flush of accumulator, FIFO and sticky flags
//   out_ready   consumer accepts out_data this cycle
//   out_valid   FIFO non-empty
//   out_data    head-of-FIFO averaged code (0 when empty)
//   fifo_level  occupied FIFO entries
//   code_err    sticky: a captured word failed the complement check
//   phase_err   sticky: sample and comp_en were high together
//   ovf         sticky: a result was dropped on a full FIFO

module sar_code_accum #(
  parameter int WIDTH      = 6,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          comp_en,
  input  logic                          sample,
  input  logic [WIDTH-1:0]              d_code,
  input  logic [WIDTH-1:0]              d_code_b,
  input  logic                          clr,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          code_err,
  output logic                          phase_err,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = WIDTH + AVG_LOG2;
  // Keep the counter at least one bit wide so AVG_LOG2 = 0 still elaborates;
  // in that case it stays at 0 and every valid word completes a group.
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** AVG_LOG2) - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic                 r_comp_en_q;
  logic [SW-1:0]        r_acc;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_code_err;
  logic                 r_phase_err;
  logic                 r_ovf;

  logic                 w_eoc;
  logic                 w_word_ok;
  logic [SW-1:0]        w_sum;
  logic                 w_last;
  logic                 w_push;
  logic [WIDTH-1:0]     w_push_data;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;

  assign w_eoc       = r_comp_en_q & ~comp_en;
  assign w_word_ok   = &(d_code ^ d_code_b);
  assign w_sum       = r_acc + SW'(d_code);
  assign w_last      = (r_cnt == CNT_LAST);
  assign w_push      = w_eoc & w_word_ok & w_last;
  // Truncating divide by 2^AVG_LOG2: the mean is the top WIDTH bits of the sum.
  assign w_push_data = w_sum[SW-1:AVG_LOG2];

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == FULL_LVL);
  assign w_pop       = ~w_empty & out_ready;
  // A push into a full FIFO is accepted only if the head leaves in the same cycle.
  assign w_wr        = w_push & (~w_full | w_pop);

  assign out_valid   = ~w_empty;
  assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_level  = r_level;
  assign code_err    = r_code_err;
  assign phase_err   = r_phase_err;
  assign ovf         = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp_en_q <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_code_err  <= 1'b0;
      r_phase_err <= 1'b0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // The edge detector keeps running through clr so a window that spans
      // the flush still produces its end-of-conversion afterwards.
      r_comp_en_q <= comp_en;
      if (clr) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_level     <= '0;
        r_code_err  <= 1'b0;
        r_phase_err <= 1'b0;
        r_ovf       <= 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
        if (sample & comp_en) r_phase_err <= 1'b1;

        if (w_eoc) begin
          if (!w_word_ok) begin
            r_code_err <= 1'b1;
          end else if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CW'(1);
          end
        end

        if (w_push & ~w_wr) r_ovf <= 1'b1;

        if (w_wr) begin
          r_mem[r_wr_ptr] <= w_push_data;
          r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

        case ({w_wr, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_code_accum.sv
// tb/tb_sar_code_accum.sv - directed self-checking bench for sar_code_accum

module tb_sar_code_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       comp_en;
  logic       sample;
  logic [5:0] d_code;
  logic [5:0] d_code_b;
  logic       clr;
  logic       out_ready;
  logic       out_valid;
  logic [5:0] out_data;
  logic [2:0] fifo_level;
  logic       code_err;
  logic       phase_err;
  logic       ovf;

  int tests_run = 0;
  int tests_failed = 0;

  sar_code_accum #(.WIDTH(6), .AVG_LOG2(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .comp_en    (comp_en),
    .sample     (sample),
    .d_code     (d_code),
    .d_code_b   (d_code_b),
    .clr        (clr),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .code_err   (code_err),
    .phase_err  (phase_err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // One conversion: a one-cycle comp_en window, then the eoc cycle with the word.
  // Returns at the falling edge after the capturing rising edge.
  task automatic conv(input logic [5:0] c, input logic [5:0] cb);
    @(negedge clk);
    comp_en = 1'b1;
    @(negedge clk);
    comp_en  = 1'b0;
    d_code   = c;
    d_code_b = cb;
    @(negedge clk);
  endtask

  task automatic do_group(input logic [5:0] c);
    for (int i = 0; i < 4; i++) conv(c, ~c);
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, out_data, fifo_level, code_err, phase_err, ovf} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%0b data=%0d lvl=%0d cerr=%0b perr=%0b ovf=%0b, want all 0",
               out_valid, out_data, fifo_level, code_err, phase_err, ovf);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    do_group(6'd2);
    // Overlapping sample/comp_en window with a non-complementary word sets both flags.
    @(negedge clk);
    d_code = 6'd5; d_code_b = 6'd5; comp_en = 1'b1; sample = 1'b1;
    @(negedge clk);
    comp_en = 1'b0; sample = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({fifo_level, code_err, phase_err} !== {3'd1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_pre: got lvl=%0d cerr=%0b perr=%0b, want 1 1 1", fifo_level, code_err, phase_err);
    end
    conv(6'd3, ~6'd3);
    conv(6'd3, ~6'd3);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_data, fifo_level, code_err, phase_err, ovf} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_async: got valid=%0b data=%0d lvl=%0d cerr=%0b perr=%0b ovf=%0b, want all 0",
               out_valid, out_data, fifo_level, code_err, phase_err, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_group(6'd8);
    tests_run++;
    if ({out_valid, out_data, fifo_level} !== {1'b1, 6'd8, 3'd1}) begin
      tests_failed++;
      $display("FAIL reset_fresh_group: got valid=%0b data=%0d lvl=%0d, want 1 8 1", out_valid, out_data, fifo_level);
    end
    pop_one();
  endtask

  task automatic test_averaging();
    out_ready = 1'b1;
    conv(6'd10, ~6'd10);
    conv(6'd11, ~6'd11);
    conv(6'd12, ~6'd12);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL avg_early_valid: got %0b, want 0", out_valid);
    end
    conv(6'd13, ~6'd13);
    tests_run++;
    if ({out_valid, out_data} !== {1'b1, 6'd11}) begin
      tests_failed++;
      $display("FAIL avg_result: got valid=%0b data=%0d, want 1 11", out_valid, out_data);
    end
    @(negedge clk);
    tests_run++;
    if ({out_valid, fifo_level} !== {1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL avg_popped: got valid=%0b lvl=%0d, want 0 0", out_valid, fifo_level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_code_err();
    conv(6'd4, ~6'd4);
    conv(6'd5, 6'd0);
    tests_run++;
    if (code_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL cerr_flag: got %0b, want 1", code_err);
    end
    conv(6'd4, ~6'd4);
    conv(6'd4, ~6'd4);
    tests_run++;
    if (fifo_level !== 3'd0) begin
      tests_failed++;
      $display("FAIL cerr_skipped: got lvl=%0d, want 0", fifo_level);
    end
    conv(6'd4, ~6'd4);
    tests_run++;
    if ({fifo_level, out_data} !== {3'd1, 6'd4}) begin
      tests_failed++;
      $display("FAIL cerr_result: got lvl=%0d data=%0d, want 1 4", fifo_level, out_data);
    end
    pop_one();
    pulse_clr();
    tests_run++;
    if (code_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL cerr_clr: got %0b, want 0", code_err);
    end
  endtask

  task automatic test_overflow_order();
    logic [5:0] exp_v;
    out_ready = 1'b0;
    for (int g = 1; g <= 5; g++) do_group(6'(g));
    tests_run++;
    if ({fifo_level, ovf} !== {3'd4, 1'b1}) begin
      tests_failed++;
      $display("FAIL ovf_full: got lvl=%0d ovf=%0b, want 4 1", fifo_level, ovf);
    end
    for (int k = 1; k <= 4; k++) begin
      exp_v = 6'(k);
      tests_run++;
      if ({out_valid, out_data} !== {1'b1, exp_v}) begin
        tests_failed++;
        $display("FAIL ovf_order_%0d: got valid=%0b data=%0d, want 1 %0d", k, out_valid, out_data, exp_v);
      end
      pop_one();
    end
    tests_run++;
    if ({out_valid, out_data, fifo_level} !== {1'b0, 6'd0, 3'd0}) begin
      tests_failed++;
      $display("FAIL ovf_drained: got valid=%0b data=%0d lvl=%0d, want 0 0 0", out_valid, out_data, fifo_level);
    end
    pulse_clr();
  endtask

  task automatic test_full_push_pop();
    logic [5:0] exp_q [5];
    exp_q = '{6'd21, 6'd22, 6'd23, 6'd30, 6'd0};
    out_ready = 1'b0;
    for (int g = 20; g <= 23; g++) do_group(6'(g));
    for (int i = 0; i < 3; i++) conv(6'd30, ~6'd30);
    @(negedge clk);
    comp_en = 1'b1;
    @(negedge clk);
    comp_en = 1'b0; d_code = 6'd30; d_code_b = ~6'd30; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if ({fifo_level, ovf, out_data} !== {3'd4, 1'b0, 6'd21}) begin
      tests_failed++;
      $display("FAIL full_push_pop: got lvl=%0d ovf=%0b head=%0d, want 4 0 21", fifo_level, ovf, out_data);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (out_data !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL full_drain_%0d: got %0d, want %0d", k, out_data, exp_q[k]);
      end
      pop_one();
    end
  endtask

  task automatic test_max_clr();
    out_ready = 1'b0;
    // Max code with sample overlapping the window: phase_err set, capture unaffected.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      comp_en = 1'b1; sample = 1'b1;
      @(negedge clk);
      comp_en = 1'b0; sample = 1'b0; d_code = 6'd63; d_code_b = 6'd0;
      @(negedge clk);
    end
    tests_run++;
    if ({out_data, fifo_level, phase_err} !== {6'd63, 3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL max_code: got data=%0d lvl=%0d perr=%0b, want 63 1 1", out_data, fifo_level, phase_err);
    end
    for (int g = 0; g < 4; g++) do_group(6'd63);
    conv(6'd1, 6'd1);
    tests_run++;
    if ({fifo_level, ovf, code_err} !== {3'd4, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL max_flags: got lvl=%0d ovf=%0b cerr=%0b, want 4 1 1", fifo_level, ovf, code_err);
    end
    pulse_clr();
    tests_run++;
    if ({out_valid, fifo_level, code_err, ovf, phase_err} !== 7'd0) begin
      tests_failed++;
      $display("FAIL clr_state: got valid=%0b lvl=%0d cerr=%0b ovf=%0b perr=%0b, want all 0",
               out_valid, fifo_level, code_err, ovf, phase_err);
    end
  endtask

  initial begin
    rst_n = 1'b0; comp_en = 1'b0; sample = 1'b0; d_code = '0; d_code_b = '0;
    clr = 1'b0; out_ready = 1'b0;
    test_reset();
    test_averaging();
    test_code_err();
    test_overflow_order();
    test_full_push_pop();
    test_max_clr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
